// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
//   Upstream feeder for the VGA note renderer. Pulls 4-bit note-chart words
//   (one bit per lane) and turns each set bit into a falling note held in a
//   per-lane slot pool. Every frame all live notes move down and notes that
//   leave the screen are retired. For the scanned pixel (x,y) it reports, one
//   cycle later, which lanes' note colour should be drawn.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   1-cycle pulse, IDLE -> RUN
//   frame_tick   in   1   1-cycle pulse per video frame
//   chart_valid  in   1   chart_notes is valid
//   chart_notes  in   4   bit i = note in lane i
//   chart_last   in   1   qualifies the final chart word
//   chart_ready  out  1   1-cycle accept pulse for the chart word
//   x            in   10  scan x
//   y            in   9   scan y
//   lane_hit     out  4   bit i = (x,y) inside a live lane-i note (1-cycle latency)
//   miss         out  4   1-cycle pulse: a lane-i note retired off the screen
//   overflow     out  1   sticky: a spawn was dropped because its lane was full
//   live_count   out  5   number of live notes over all lanes
//   done         out  1   chart exhausted and no live notes
module note_lane_scheduler #(
  parameter int SLOTS        = 4,
  parameter int SPAWN_FRAMES = 120,
  parameter int NOTE_SPEED   = 1,
  parameter int NOTE_WIDTH   = 50,
  parameter int LANE_X0      = 170,
  parameter int LANE_PITCH   = 100,
  parameter int VIDEO_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       chart_valid,
  input  logic [3:0] chart_notes,
  input  logic       chart_last,
  output logic       chart_ready,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [3:0] lane_hit,
  output logic [3:0] miss,
  output logic       overflow,
  output logic [4:0] live_count,
  output logic       done
);

  localparam int LANES = 4;
  localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                                state, state_nxt;
  logic [CNT_W-1:0]                      frame_cnt, frame_cnt_nxt;
  logic [LANES-1:0][SLOTS-1:0]           slot_valid, valid_nxt;
  logic [LANES-1:0][SLOTS-1:0][9:0]      slot_pos, pos_nxt;
  logic [3:0]                            retire;
  logic                                  drop;
  logic [3:0]                            hit_nxt;
  logic [4:0]                            count_nxt;
  logic                                  move_en;
  logic                                  spawn_en;

  // Control FSM. The frame counter only advances in RUN; the wrap tick opens
  // a one-cycle FETCH window in which the chart word is accepted (or skipped).
  // DRAIN leaves as soon as no slot is valid, so done rises in the same cycle
  // that the registered live_count reaches zero.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    chart_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_RUN;
          frame_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        if (frame_tick) begin
          if (frame_cnt == CNT_W'(SPAWN_FRAMES - 1)) begin
            frame_cnt_nxt = '0;
            state_nxt     = S_FETCH;
          end else begin
            frame_cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
      end
      S_FETCH: begin
        if (chart_valid) begin
          chart_ready = 1'b1;
          state_nxt   = chart_last ? S_DRAIN : S_RUN;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (slot_valid == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign done     = (state == S_DONE);
  assign move_en  = frame_tick && (state != S_IDLE);
  assign spawn_en = chart_ready;

  // Slot update. Moves and spawns look at the current valid bits, so a note
  // spawned this cycle is never moved, and a slot retiring this cycle is
  // still seen as occupied by the spawn search.
  always_comb begin
    logic [10:0] sum;
    logic        found;
    valid_nxt = slot_valid;
    pos_nxt   = slot_pos;
    retire    = '0;
    drop      = 1'b0;
    sum       = '0;
    found     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        sum = {1'b0, slot_pos[l][s]} + 11'(NOTE_SPEED);
        if (move_en && slot_valid[l][s]) begin
          if (sum >= 11'(VIDEO_HEIGHT)) begin
            valid_nxt[l][s] = 1'b0;
            retire[l]       = 1'b1;
          end else begin
            pos_nxt[l][s] = sum[9:0];
          end
        end
      end
      if (spawn_en && chart_notes[l]) begin
        found = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
          if (!found && !slot_valid[l][s]) begin
            valid_nxt[l][s] = 1'b1;
            pos_nxt[l][s]   = '0;
            found           = 1'b1;
          end
        end
        if (!found) begin
          drop = 1'b1;
        end
      end
    end
  end

  // Pixel hit test against every live note, done in 11 bits so the lower
  // edge of a note near the bottom never wraps back to the top.
  always_comb begin
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] lane_lo;
    logic [10:0] p11;
    hit_nxt = '0;
    x11     = {1'b0, x};
    y11     = {2'b0, y};
    lane_lo = '0;
    p11     = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_lo = 11'(LANE_X0 + l * LANE_PITCH);
      for (int s = 0; s < SLOTS; s++) begin
        p11 = {1'b0, slot_pos[l][s]};
        if (slot_valid[l][s] &&
            (x11 >= lane_lo) && (x11 < lane_lo + 11'(NOTE_WIDTH)) &&
            (y11 >= p11) && (y11 < p11 + 11'(NOTE_WIDTH))) begin
          hit_nxt[l] = 1'b1;
        end
      end
    end
  end

  // Popcount of the current valid bits; registered, so live_count trails
  // the slot change by one cycle.
  always_comb begin
    count_nxt = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        count_nxt = count_nxt + 5'(slot_valid[l][s]);
      end
    end
  end

  // State and output registers. Reset discards notes silently: miss is
  // cleared along with everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      frame_cnt  <= '0;
      slot_valid <= '0;
      slot_pos   <= '0;
      lane_hit   <= '0;
      miss       <= '0;
      overflow   <= 1'b0;
      live_count <= '0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_cnt_nxt;
      slot_valid <= valid_nxt;
      slot_pos   <= pos_nxt;
      lane_hit   <= hit_nxt;
      miss       <= retire;
      overflow   <= overflow | drop;
      live_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// tb_note_lane_scheduler
//   Directed bench for note_lane_scheduler. Instance a uses the default
//   parameters; instance b shares all stimulus but fetches every 2 frames so
//   a lane can be overfilled before its notes can retire.
module tb_note_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic       chart_valid;
  logic [3:0] chart_notes;
  logic       chart_last;
  logic [9:0] x;
  logic [8:0] y;

  logic       a_chart_ready, b_chart_ready;
  logic [3:0] a_lane_hit, b_lane_hit;
  logic [3:0] a_miss, b_miss;
  logic       a_overflow, b_overflow;
  logic [4:0] a_live_count, b_live_count;
  logic       a_done, b_done;

  int errors = 0;
  int checks = 0;
  int a_ready_cnt = 0;
  int a_miss_cnt = 0;
  int base_ready;
  int base_miss;

  note_lane_scheduler dut_a (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .chart_valid(chart_valid), .chart_notes(chart_notes), .chart_last(chart_last),
    .chart_ready(a_chart_ready), .x(x), .y(y), .lane_hit(a_lane_hit),
    .miss(a_miss), .overflow(a_overflow), .live_count(a_live_count), .done(a_done)
  );

  note_lane_scheduler #(.SPAWN_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .chart_valid(chart_valid), .chart_notes(chart_notes), .chart_last(chart_last),
    .chart_ready(b_chart_ready), .x(x), .y(y), .lane_hit(b_lane_hit),
    .miss(b_miss), .overflow(b_overflow), .live_count(b_live_count), .done(b_done)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (a_chart_ready) a_ready_cnt <= a_ready_cnt + 1;
    if (a_miss != 4'b0000) a_miss_cnt <= a_miss_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    frame_tick  = 1'b0;
    chart_valid = 1'b0;
    chart_notes = 4'b0000;
    chart_last  = 1'b0;
    x           = 10'd0;
    y           = 9'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns on the falling edge right after the tick was captured.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic query(input logic [9:0] qx, input logic [8:0] qy);
    @(negedge clk);
    x = qx;
    y = qy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b1;
    start = 1'b0; frame_tick = 1'b0; chart_valid = 1'b0;
    chart_notes = 4'b0000; chart_last = 1'b0; x = 10'd0; y = 9'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_chart_ready, a_lane_hit, a_miss, a_overflow, a_live_count, a_done} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0000",
               {a_chart_ready, a_lane_hit, a_miss, a_overflow, a_live_count, a_done});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_live_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: got done=%b live=%0d expected done=0 live=0",
               a_done, a_live_count);
    end
  endtask

  task automatic test_spawn();
    $display("[TB] test_spawn");
    do_reset();
    ticks(5);
    pulse_start();
    chart_valid = 1'b1;
    chart_notes = 4'b0101;
    base_ready  = a_ready_cnt;
    ticks(119);
    checks++;
    if (a_ready_cnt - base_ready !== 0) begin
      errors++;
      $display("[TB] FAIL early_ready: got %0d pulses expected 0", a_ready_cnt - base_ready);
    end
    tick();
    checks++;
    if (a_chart_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_pulse: got %b expected 1", a_chart_ready);
    end
    @(negedge clk);
    checks++;
    if (a_chart_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_width: got %b expected 0", a_chart_ready);
    end
    chart_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_live_count !== 5'd2) begin
      errors++;
      $display("[TB] FAIL spawn_live: got %0d expected 2", a_live_count);
    end
    query(10'd170, 9'd0);
    checks++;
    if (a_lane_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL spawn_lane0: got %b expected 0001", a_lane_hit);
    end
    query(10'd370, 9'd0);
    checks++;
    if (a_lane_hit !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL spawn_lane2: got %b expected 0100", a_lane_hit);
    end
    query(10'd270, 9'd0);
    checks++;
    if (a_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL spawn_lane1_empty: got %b expected 0000", a_lane_hit);
    end
  endtask

  task automatic test_hit();
    $display("[TB] test_hit");
    ticks(10);
    query(10'd170, 9'd10);
    checks++;
    if (a_lane_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL hit_top: got %b expected 0001", a_lane_hit);
    end
    @(negedge clk);
    x = 10'd170;
    y = 9'd60;
    #1;
    checks++;
    if (a_lane_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL hit_latency: got %b expected 0001", a_lane_hit);
    end
    @(negedge clk);
    checks++;
    if (a_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL hit_below: got %b expected 0000", a_lane_hit);
    end
    query(10'd219, 9'd59);
    checks++;
    if (a_lane_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL hit_corner: got %b expected 0001", a_lane_hit);
    end
    query(10'd220, 9'd10);
    checks++;
    if (a_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL hit_right_edge: got %b expected 0000", a_lane_hit);
    end
    query(10'd169, 9'd10);
    checks++;
    if (a_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL hit_left_edge: got %b expected 0000", a_lane_hit);
    end
    query(10'd370, 9'd9);
    checks++;
    if (a_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL hit_above: got %b expected 0000", a_lane_hit);
    end
  endtask

  task automatic test_retire();
    $display("[TB] test_retire");
    do_reset();
    pulse_start();
    chart_valid = 1'b1;
    chart_notes = 4'b0010;
    ticks(120);
    @(negedge clk);
    chart_valid = 1'b0;
    base_miss = a_miss_cnt;
    ticks(460);
    query(10'd270, 9'd479);
    checks++;
    if (a_lane_hit !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bottom_row: got %b expected 0010", a_lane_hit);
    end
    query(10'd270, 9'd459);
    checks++;
    if (a_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL above_460: got %b expected 0000", a_lane_hit);
    end
    query(10'd270, 9'd460);
    checks++;
    if (a_lane_hit !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL row_460: got %b expected 0010", a_lane_hit);
    end
    ticks(19);
    checks++;
    if (a_miss_cnt - base_miss !== 0 || a_live_count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL pre_retire: got misses=%0d live=%0d expected misses=0 live=1",
               a_miss_cnt - base_miss, a_live_count);
    end
    tick();
    checks++;
    if (a_miss !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL miss_pulse: got %b expected 0010", a_miss);
    end
    @(negedge clk);
    checks++;
    if (a_miss !== 4'b0000 || a_live_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL post_retire: got miss=%b live=%0d expected miss=0000 live=0",
               a_miss, a_live_count);
    end
  endtask

  task automatic test_overflow();
    $display("[TB] test_overflow");
    do_reset();
    pulse_start();
    chart_valid = 1'b1;
    chart_notes = 4'b1000;
    ticks(8);
    repeat (2) @(negedge clk);
    checks++;
    if (b_live_count !== 5'd4 || b_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lane_full: got live=%0d ovf=%b expected live=4 ovf=0",
               b_live_count, b_overflow);
    end
    ticks(2);
    repeat (2) @(negedge clk);
    checks++;
    if (b_live_count !== 5'd4 || b_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: got live=%0d ovf=%b expected live=4 ovf=1",
               b_live_count, b_overflow);
    end
    chart_notes = 4'b1001;
    ticks(2);
    repeat (2) @(negedge clk);
    chart_valid = 1'b0;
    checks++;
    if (b_live_count !== 5'd5 || b_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL other_lane: got live=%0d ovf=%b expected live=5 ovf=1",
               b_live_count, b_overflow);
    end
    query(10'd470, 9'd4);
    checks++;
    if (b_lane_hit !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL lane3_newest: got %b expected 1000", b_lane_hit);
    end
    query(10'd470, 9'd3);
    checks++;
    if (b_lane_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL dropped_note: got %b expected 0000", b_lane_hit);
    end
    query(10'd170, 9'd0);
    checks++;
    if (b_lane_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL lane0_spawn: got %b expected 0001", b_lane_hit);
    end
  endtask

  task automatic test_drain();
    $display("[TB] test_drain");
    do_reset();
    pulse_start();
    chart_valid = 1'b1;
    chart_notes = 4'b0001;
    chart_last  = 1'b1;
    base_ready  = a_ready_cnt;
    ticks(120);
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_entry: got done=%b expected 0", a_done);
    end
    ticks(479);
    checks++;
    if (a_done !== 1'b0 || a_live_count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL drain_hold: got done=%b live=%0d expected done=0 live=1",
               a_done, a_live_count);
    end
    tick();
    checks++;
    if (a_miss !== 4'b0001 || a_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_retire: got miss=%b done=%b expected miss=0001 done=0",
               a_miss, a_done);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_live_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL done_rise: got done=%b live=%0d expected done=1 live=0",
               a_done, a_live_count);
    end
    pulse_start();
    ticks(3);
    checks++;
    if (a_done !== 1'b1 || a_ready_cnt - base_ready !== 1) begin
      errors++;
      $display("[TB] FAIL done_hold: got done=%b fetches=%0d expected done=1 fetches=1",
               a_done, a_ready_cnt - base_ready);
    end
    chart_valid = 1'b0;
    chart_last  = 1'b0;
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    do_reset();
    pulse_start();
    chart_valid = 1'b1;
    chart_notes = 4'b0111;
    ticks(120);
    @(negedge clk);
    chart_valid = 1'b0;
    ticks(5);
    query(10'd170, 9'd5);
    checks++;
    if (a_live_count !== 5'd3 || a_lane_hit !== 4'b0001 || b_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: got live=%0d hit=%b ovf_b=%b expected live=3 hit=0001 ovf_b=1",
               a_live_count, a_lane_hit, b_overflow);
    end
    base_miss  = a_miss_cnt;
    base_ready = a_ready_cnt;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({a_chart_ready, a_lane_hit, a_miss, a_overflow, a_live_count, a_done, b_overflow} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL async_clear: got %h expected 00000",
               {a_chart_ready, a_lane_hit, a_miss, a_overflow, a_live_count, a_done, b_overflow});
    end
    ticks(3);
    reset = 1'b0;
    ticks(130);
    @(negedge clk);
    checks++;
    if (a_miss_cnt - base_miss !== 0 || a_ready_cnt - base_ready !== 0 || a_live_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got misses=%0d fetches=%0d live=%0d expected 0 0 0",
               a_miss_cnt - base_miss, a_ready_cnt - base_ready, a_live_count);
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_hit();
    test_retire();
    test_overflow();
    test_drain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
